// File: rtl/mips_encode_pkg.sv
// mips_encode_pkg: constant set shared by the encoder and its FIFO.
// Holds the ALU operation codes, the I-type opcodes and R-type funct codes,
// the FIFO entry layout, and the combinational encode/legality function.
package mips_encode_pkg;

  // ALU operation codes. Codes 0 and 1 are not encodable.
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // Primary opcodes.
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  // R-type funct codes (opcode OP_OTHER0).
  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fifo_entry_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Build the instruction word; legal=0 marks combinations with no encoding.
  function automatic enc_t encode(input logic [2:0]  op,
                                  input logic        src2,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  rs,
                                  input logic [4:0]  rt,
                                  input logic [15:0] imm);
    enc_t       e;
    logic [5:0] code;
    e.legal = 1'b1;
    code    = 6'h00;
    if (!src2) begin
      case (op)
        ALU_ADD: code = OP0_ADD;
        ALU_SUB: code = OP0_SUB;
        ALU_AND: code = OP0_AND;
        ALU_OR:  code = OP0_OR;
        ALU_NOR: code = OP0_NOR;
        ALU_XOR: code = OP0_XOR;
        default: e.legal = 1'b0;
      endcase
      e.word = {OP_OTHER0, rs, rt, rd, 5'b0, code};
    end else begin
      // Immediate forms: destination sits in the rt field; rt input unused.
      case (op)
        ALU_ADD: code = OP_ADDI;
        ALU_AND: code = OP_ANDI;
        ALU_OR:  code = OP_ORI;
        ALU_XOR: code = OP_XORI;
        default: e.legal = 1'b0;
      endcase
      e.word = {code, rs, rd, imm};
    end
    return e;
  endfunction

endpackage

// File: rtl/mips_encode_fifo.sv
// mips_encode_fifo: 2-deep, 64-bit synchronous FIFO of {inst, pc}.
// Ports: clk, reset (sync, active-high), push/din write side,
// pop read side, full/empty status, dout = head entry (zero after reset).
// Push while full and pop while empty are ignored.
module mips_encode_fifo
  import mips_encode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] din,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [63:0] dout
);

  logic [63:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are cleared on reset so the head reads zero when idle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q[gi] <= 64'd0;
      end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/mips_encode.sv
// mips_encode: sequential MIPS R/I-type instruction encoder.
// Ports: clk, reset (sync, active-high); input handshake in_valid/in_ready
// with fields alu_op, alu_src2, rd, rs, rt, imm; output handshake
// out_valid/out_ready with inst and pc; except pulses one cycle after an
// unencodable input is accepted.
module mips_encode
  import mips_encode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic        alu_src2,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        except
);

  logic [31:0] pc_q, pc_d;
  logic        except_q, except_d;
  logic        accept, push, full, empty;
  enc_t        enc;
  fifo_entry_t head;

  assign enc = encode(alu_op, alu_src2, rd, rs, rt, imm);

  // Readiness is purely the registered FIFO level: no bypass when full.
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.legal;

  always_comb begin
    pc_d     = push ? pc_q + 32'd4 : pc_q;
    except_d = accept & ~enc.legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      except_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      except_q <= except_d;
    end
  end

  mips_encode_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({enc.word, pc_q}),
    .pop   (out_ready),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  assign out_valid = ~empty;
  assign inst      = head.inst;
  assign pc        = head.pc;
  assign except    = except_q;

endmodule

// File: tb/tb_mips_encode.sv
module tb_mips_encode;

  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  alu_op = 3'd0;
  logic        alu_src2 = 1'b0;
  logic [4:0]  rd = 5'd0, rs = 5'd0, rt = 5'd0;
  logic [15:0] imm = 16'd0;
  logic        out_valid, out_ready = 1'b0, except;
  logic [31:0] inst, pc;

  // Second instance for the PC wrap scenario.
  logic        reset2 = 1'b1, in_valid2 = 1'b0, in_ready2;
  logic        out_valid2, out_ready2 = 1'b0, except2;
  logic [31:0] inst2, pc2;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_exc;

  always #5 clk = ~clk;

  mips_encode #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src2(alu_src2), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .pc(pc),
    .except(except)
  );

  mips_encode #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(3'd2), .alu_src2(1'b0), .rd(5'd3), .rs(5'd1), .rt(5'd2), .imm(16'd0),
    .out_valid(out_valid2), .out_ready(out_ready2), .inst(inst2), .pc(pc2),
    .except(except2)
  );

  // Reference: table lookup of funct/opcode, -1 meaning no encoding.
  function automatic int ref_code(input logic [2:0] op, input logic src2);
    int rtab [8] = '{-1, -1, 'h20, 'h22, 'h24, 'h25, 'h27, 'h26};
    int itab [8] = '{-1, -1, 'h08, -1, 'h0c, 'h0d, -1, 'h0e};
    return src2 ? itab[op] : rtab[op];
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] op, input logic src2,
                                           input logic [4:0] d, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
    int c = ref_code(op, src2);
    if (src2)
      return (32'(c) << 26) + (32'(s) << 21) + (32'(d) << 16) + 32'(im);
    return (32'(s) << 21) + (32'(t) << 16) + (32'(d) << 11) + 32'(c);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_pc  = RPC;
    m_exc = 1'b0;
  endtask

  // Drive one cycle and advance the reference across the edge.
  task automatic drive(input logic iv, input logic [2:0] op, input logic src2,
                       input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                       input logic [15:0] im, input logic ordy);
    logic acc;
    @(negedge clk);
    in_valid = iv; alu_op = op; alu_src2 = src2;
    rd = d; rs = s; rt = t; imm = im; out_ready = ordy;
    @(posedge clk);
    acc   = iv && (exp_q.size() != 2);
    m_exc = acc && (ref_code(op, src2) < 0);
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc && ref_code(op, src2) >= 0) begin
      exp_q.push_back({ref_word(op, src2, d, s, t, im), m_pc});
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 16'd0, ordy);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, in_ready, except} !== 3'b010 || inst !== 32'd0 || pc !== 32'd0) begin
      errors++;
      $display("FAIL reset: ov/ir/ex=%b%b%b inst=%h pc=%h required 010 0 0",
               out_valid, in_ready, except, inst, pc);
    end
    $display("reset: ov=%b ir=%b ex=%b", out_valid, in_ready, except);
  endtask

  task automatic test_basic_add();
    do_reset();
    drive(1'b1, 3'd2, 1'b0, 5'd3, 5'd1, 5'd2, 16'h1234, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || inst !== 32'h00221820 || pc !== 32'h00400000 || except !== 1'b0) begin
      errors++;
      $display("FAIL basic_add: ov=%b inst=%h pc=%h ex=%b required 1 00221820 00400000 0",
               out_valid, inst, pc, except);
    end
    $display("basic_add: inst=%h pc=%h", inst, pc);
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: ov=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 3'd3, 1'b0, 5'd3, 5'd1, 5'd2, 16'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || inst !== 32'h00221822 || pc !== 32'h00400000) begin
      errors++;
      $display("FAIL b2b_sub: ov=%b inst=%h pc=%h required 1 00221822 00400000", out_valid, inst, pc);
    end
    $display("b2b_sub: inst=%h pc=%h", inst, pc);
    drive(1'b1, 3'd2, 1'b1, 5'd5, 5'd4, 5'd31, 16'hFFFF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || inst !== 32'h2085FFFF || pc !== 32'h00400004) begin
      errors++;
      $display("FAIL b2b_addi: ov=%b inst=%h pc=%h required 1 2085ffff 00400004", out_valid, inst, pc);
    end
    $display("b2b_addi: inst=%h pc=%h", inst, pc);
    idle(1'b1);
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 3'd3, 1'b1, 5'd3, 5'd1, 5'd2, 16'h0, 1'b1);
    checks++;
    if (except !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ex=%b ov=%b required 1 0", except, out_valid);
    end
    $display("illegal: ex=%b ov=%b", except, out_valid);
    drive(1'b1, 3'd2, 1'b0, 5'd3, 5'd1, 5'd2, 16'h0, 1'b1);
    checks++;
    if (except !== 1'b0 || out_valid !== 1'b1 || pc !== 32'h00400000 || inst !== 32'h00221820) begin
      errors++;
      $display("FAIL illegal_next: ex=%b ov=%b inst=%h pc=%h required 0 1 00221820 00400000",
               except, out_valid, inst, pc);
    end
    $display("after_illegal: inst=%h pc=%h", inst, pc);
    // Back-to-back illegal accepts give consecutive high cycles.
    drive(1'b1, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1);
    drive(1'b1, 3'd6, 1'b1, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1);
    checks++;
    if (except !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_b2b: ex=%b ov=%b required 1 0", except, out_valid);
    end
    idle(1'b1);
    checks++;
    if (except !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: ex=%b required 0", except);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] first;
    logic        ir_exp [3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd4 + 3'(i), 1'b0, 5'(i + 7), 5'(i), 5'(i + 1), 16'h0, 1'b0);
      if (i == 0) first = exp_q[0];
      checks++;
      if (in_ready !== ir_exp[i] || {inst, pc} !== first || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure[%0d]: ir=%b head=%h ov=%b required %b %h 1",
                 i, in_ready, {inst, pc}, out_valid, ir_exp[i], first);
      end
      $display("backpressure[%0d]: ir=%b inst=%h pc=%h", i, in_ready, inst, pc);
    end
    // Offer the third word with out_ready raised: refused on the full cycle, then taken.
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, 3'd6, 1'b0, 5'd9, 5'd2, 5'd3, 16'h0, 1'b1);
      checks++;
      if (out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && {inst, pc} !== exp_q[0])) begin
        errors++;
        $display("FAIL drain[%0d]: ov=%b head=%h required %b %h", i, out_valid, {inst, pc},
                 exp_q.size() != 0, exp_q.size() != 0 ? exp_q[0] : 64'd0);
      end
      $display("drain[%0d]: ov=%b inst=%h pc=%h", i, out_valid, inst, pc);
    end
    checks++;
    if (m_pc !== 32'h0040000C || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_count: model pc=%h q=%0d required 0040000c 0", m_pc, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reset2 = 1'b1;
    @(negedge clk);
    reset2 = 1'b0;
    in_valid2 = 1'b1;
    out_ready2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    checks++;
    if (out_valid2 !== 1'b1 || pc2 !== RPC2 || in_ready2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first: ov=%b pc=%h ir=%b required 1 fffffffc 0", out_valid2, pc2, in_ready2);
    end
    $display("wrap: pc=%h", pc2);
    out_ready2 = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || pc2 !== 32'h0 || inst2 !== 32'h00221820) begin
      errors++;
      $display("FAIL wrap_second: ov=%b pc=%h inst=%h required 1 00000000 00221820", out_valid2, pc2, inst2);
    end
    $display("wrap: pc=%h", pc2);
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd3, 16'hA5A5, 1'b0);
    drive(1'b1, 3'd7, 1'b1, 5'd4, 5'd5, 5'd6, 16'h5A5A, 1'b0);
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || except !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b ir=%b ex=%b required 0 1 0", out_valid, in_ready, except);
    end
    drive(1'b1, 3'd7, 1'b0, 5'd8, 5'd9, 5'd10, 16'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || pc !== RPC || inst !== exp_q[0][63:32]) begin
      errors++;
      $display("FAIL reset_mid_pc: ov=%b pc=%h inst=%h required 1 %h %h", out_valid, pc, inst, RPC, exp_q[0][63:32]);
    end
    $display("reset_mid: inst=%h pc=%h", inst, pc);
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) != 0));
      checks++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != 2) ||
          except !== m_exc || (exp_q.size() != 0 && {inst, pc} !== exp_q[0])) begin
        errors++;
        bad++;
        $display("FAIL random[%0d]: ov=%b ir=%b ex=%b head=%h required %b %b %b %h", i,
                 out_valid, in_ready, except, {inst, pc}, exp_q.size() != 0,
                 exp_q.size() != 2, m_exc, exp_q.size() != 0 ? exp_q[0] : 64'd0);
      end
    end
    $display("random: 400 cycles, %0d bad", bad);
  endtask

  initial begin
    m_pc  = RPC;
    m_exc = 1'b0;
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
